// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between an ICache refill
// requester and a DCache refill/writeback requester. A winning requester
// owns the port for one whole cache line (LINE_WORDS beats, each beat
// completed by MemAck). The transfer ends with a one-cycle Done pulse.
//
// Ports
//   CpuClk, CpuRst      clock (rising edge), async active-high reset
//   IReq/IAddr          ICache refill request (level) and miss address
//   DReq/DWe/DAddr      DCache request, writeback(1)/refill(0), line address
//   DWdata              writeback word for the current WordIdx
//   IGnt/DGnt           current owner of the memory port
//   IDone/DDone         one-cycle completion pulse to the owner
//   RdValid/RdData      refill word returned this cycle
//   WordIdx             index of the word being transferred
//   MemReq/MemWe/MemAddr/MemWdata/MemRdata/MemAck  word memory port
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests in favour of the requester not served last. Without it, D
// always beats I.
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int WORD_BITS  = 32
) (
  input  logic                          CpuClk,
  input  logic                          CpuRst,
  input  logic                          IReq,
  input  logic [31:0]                   IAddr,
  input  logic                          DReq,
  input  logic                          DWe,
  input  logic [31:0]                   DAddr,
  input  logic [WORD_BITS-1:0]          DWdata,
  output logic                          IGnt,
  output logic                          DGnt,
  output logic                          IDone,
  output logic                          DDone,
  output logic                          RdValid,
  output logic [WORD_BITS-1:0]          RdData,
  output logic [$clog2(LINE_WORDS)-1:0] WordIdx,
  output logic                          MemReq,
  output logic                          MemWe,
  output logic [31:0]                   MemAddr,
  output logic [WORD_BITS-1:0]          MemWdata,
  input  logic [WORD_BITS-1:0]          MemRdata,
  input  logic                          MemAck
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  // Byte-offset mask of one line: low IDX_W+2 address bits.
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t             state, state_nxt;
  logic               owner_d;   // 1: D owns the line, 0: I owns it
  logic               wr;        // latched DWe of a D owner
  logic [31:0]        base;
  logic [IDX_W-1:0]   word_idx;
  logic               grant;
  logic               win_d;
  logic [31:0]        line_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic pref_d;  // who wins the next tie; D after reset
  assign win_d = DReq & (~IReq | pref_d);
`else
  assign win_d = DReq;
`endif

  assign line_addr = (win_d ? DAddr : IAddr) & ~LINE_MASK;
  assign WordIdx   = word_idx;

  always_ff @(posedge CpuClk or posedge CpuRst) begin
    if (CpuRst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    IGnt      = 1'b0;
    DGnt      = 1'b0;
    IDone     = 1'b0;
    DDone     = 1'b0;
    RdValid   = 1'b0;
    RdData    = '0;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    MemAddr   = '0;
    MemWdata  = '0;
    case (state)
      IDLE: begin
        if (IReq | DReq) begin
          grant     = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        IGnt     = ~owner_d;
        DGnt     = owner_d;
        MemReq   = 1'b1;
        MemWe    = owner_d & wr;
        MemAddr  = base + (32'(word_idx) << 2);
        MemWdata = DWdata;
        if (MemAck) begin
          // Refill data is forwarded in the same cycle it returns.
          RdValid = ~(owner_d & wr);
          RdData  = (owner_d & wr) ? '0 : MemRdata;
          if (&word_idx) state_nxt = DONE;
        end
      end
      DONE: begin
        IDone     = ~owner_d;
        DDone     = owner_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CpuClk or posedge CpuRst) begin
    if (CpuRst) begin
      owner_d  <= 1'b0;
      wr       <= 1'b0;
      base     <= '0;
      word_idx <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pref_d   <= 1'b1;
`endif
    end else begin
      if (grant) begin
        owner_d  <= win_d;
        wr       <= win_d & DWe;
        base     <= line_addr;
        word_idx <= '0;
      end else if (state == XFER && MemAck) begin
        // Power-of-two line: the last beat wraps the index back to 0.
        word_idx <= word_idx + IDX_W'(1);
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (state == DONE) pref_d <= ~owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a line-level reference model checks
// every output on every falling edge, directed sequences pin literal
// values, then a long randomized phase runs against the model.
module tb_mem_arbiter;
  localparam int LINE_WORDS = 4;
  localparam int WORD_BITS  = 32;
  localparam int IDX_W      = 2;

  logic                 CpuClk, CpuRst;
  logic                 IReq, DReq, DWe, MemAck;
  logic [31:0]          IAddr, DAddr;
  logic [WORD_BITS-1:0] DWdata, MemRdata, dw_rand;
  logic                 wdata_follow;
  logic                 IGnt, DGnt, IDone, DDone, RdValid, MemReq, MemWe;
  logic [WORD_BITS-1:0] RdData, MemWdata;
  logic [IDX_W-1:0]     WordIdx;
  logic [31:0]          MemAddr;

  int vectors = 0;
  int miscompares = 0;

  // Writeback data tracks the word index when a directed test asks for it.
  assign DWdata = wdata_follow ? (32'hD000_0000 | 32'(WordIdx)) : dw_rand;

  mem_arbiter #(.LINE_WORDS(LINE_WORDS), .WORD_BITS(WORD_BITS)) dut (
    .CpuClk(CpuClk), .CpuRst(CpuRst), .IReq(IReq), .IAddr(IAddr),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .IGnt(IGnt), .DGnt(DGnt), .IDone(IDone), .DDone(DDone),
    .RdValid(RdValid), .RdData(RdData), .WordIdx(WordIdx),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck));

  initial CpuClk = 1'b0;
  always #5 CpuClk = ~CpuClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one line transfer at a time, tracked as
  // "busy with n acks so far", then one done cycle.
  bit          m_busy, m_done, m_own_d, m_we;
  int          m_acks;
  logic [31:0] m_base;
  bit          e_idone, e_ddone;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit          m_pref_d;
`endif

  always @(negedge CpuClk) begin
    if (CpuRst) begin
      chk("rst_gnt", {IGnt, DGnt}, 0);
      chk("rst_mem", {MemReq, MemWe, RdValid}, 0);
      chk("rst_done", {IDone, DDone}, 0);
      chk("rst_idx", 32'(WordIdx), 0);
      m_busy = 0; m_done = 0; m_own_d = 0; m_we = 0; m_acks = 0; m_base = 0;
      e_idone = 0; e_ddone = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_pref_d = 1;
`endif
    end else begin
      bit rv;
      rv = m_busy && MemAck && !(m_own_d && m_we);
      chk("ignt", 32'(IGnt), 32'(m_busy && !m_own_d));
      chk("dgnt", 32'(DGnt), 32'(m_busy && m_own_d));
      chk("idone", 32'(IDone), 32'(m_done && !m_own_d));
      chk("ddone", 32'(DDone), 32'(m_done && m_own_d));
      chk("memreq", 32'(MemReq), 32'(m_busy));
      chk("memwe", 32'(MemWe), 32'(m_busy && m_own_d && m_we));
      chk("memaddr", MemAddr, m_busy ? m_base + 32'(4 * m_acks) : 32'h0);
      chk("memwdata", MemWdata, m_busy ? DWdata : 32'h0);
      chk("rdvalid", 32'(RdValid), 32'(rv));
      chk("rddata", RdData, rv ? MemRdata : 32'h0);
      chk("wordidx", 32'(WordIdx), 32'(m_acks));
      e_idone = m_done && !m_own_d;
      e_ddone = m_done && m_own_d;
      if (m_done) begin
        m_done = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_pref_d = !m_own_d;
`endif
      end else if (m_busy) begin
        if (MemAck) begin
          m_acks++;
          if (m_acks == LINE_WORDS) begin
            m_acks = 0; m_busy = 0; m_done = 1;
          end
        end
      end else if (IReq || DReq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_own_d = DReq && (!IReq || m_pref_d);
`else
        m_own_d = DReq;
`endif
        m_base = (m_own_d ? DAddr : IAddr) & ~32'(LINE_WORDS * 4 - 1);
        m_we   = m_own_d && DWe;
        m_busy = 1;
        m_acks = 0;
      end
    end
  end

  task automatic step();
    @(posedge CpuClk); #1;
  endtask

  initial begin
    int n, rdv, done_at, writes, ddones, order_n, acks;
    int order[4];
    bit seen;
    CpuRst = 1; IReq = 0; DReq = 0; DWe = 0; MemAck = 0;
    IAddr = 0; DAddr = 0; MemRdata = 0; dw_rand = 0; wdata_follow = 0;
    step(); step();
    CpuRst = 0;
    step();

    // ICache refill at 0x1034, ack every cycle.
    MemAck = 1; MemRdata = 32'hCAFE_0001; IAddr = 32'h0000_1034; IReq = 1;
    rdv = 0; done_at = 0; seen = 0;
    for (n = 1; n <= 8; n++) begin
      @(negedge CpuClk);
      if (n >= 2 && n <= 5) chk("t1_addr", MemAddr, 32'h1030 + 32'(4 * (n - 2)));
      rdv += int'(RdValid);
      if (IDone) begin done_at = n; seen = 1; end
      step();
      if (seen) IReq = 0;
    end
    chk("t1_done_cycle", done_at, 6);
    chk("t1_rdvalid_cnt", rdv, 4);

    // DCache writeback at 0x2000, ack every third cycle.
    MemAck = 0; wdata_follow = 1; DAddr = 32'h2000; DWe = 1; DReq = 1;
    writes = 0; rdv = 0; ddones = 0;
    for (n = 0; n < 40 && ddones == 0; n++) begin
      MemAck = (n % 3 == 2);
      @(negedge CpuClk);
      if (MemReq && MemAck) begin
        chk("t2_we", 32'(MemWe), 1);
        chk("t2_idx", 32'(WordIdx), writes);
        chk("t2_wdata", MemWdata, 32'hD000_0000 | 32'(writes));
        chk("t2_addr", MemAddr, 32'h2000 + 32'(4 * writes));
        writes++;
      end
      rdv += int'(RdValid);
      ddones += int'(DDone);
      step();
    end
    DReq = 0; DWe = 0; MemAck = 0; wdata_follow = 0;
    chk("t2_writes", writes, 4);
    chk("t2_rdvalid_cnt", rdv, 0);
    chk("t2_ddone_cnt", ddones, 1);
    step();

    // Simultaneous I and D requests, twice.
    MemAck = 1; IAddr = 32'h3000; DAddr = 32'h4000; DWe = 0;
    for (int pair = 0; pair < 2; pair++) begin
      IReq = 1; DReq = 1; order_n = 0;
      for (n = 0; n < 30 && order_n < 2; n++) begin
        @(negedge CpuClk);
        if (DDone) begin order[order_n] = 1; order_n++; end
        if (IDone) begin order[order_n] = 0; order_n++; end
        step();
        if (order_n > 0 && order[order_n - 1] == 1) DReq = 0;
        if (order_n > 0 && order[order_n - 1] == 0) IReq = 0;
      end
      chk("t3_pair_cnt", order_n, 2);
      chk("t3_first_d", order[0], 1);
      chk("t3_second_i", order[1], 0);
      IReq = 0; DReq = 0;
      step();
    end

    // Reset after the second ack of an I refill; re-request restarts at 0.
    IAddr = 32'h5008; IReq = 1; acks = 0;
    for (n = 0; n < 10 && acks < 2; n++) begin
      @(negedge CpuClk);
      if (MemReq && MemAck) acks++;
      step();
    end
    chk("t4_two_acks", acks, 2);
    #1 CpuRst = 1;
    #1;
    chk("t4_rst_out", {IGnt, DGnt, MemReq, IDone, RdValid}, 0);
    chk("t4_rst_idx", 32'(WordIdx), 0);
    step();
    CpuRst = 0;
    seen = 0; done_at = 0;
    for (n = 0; n < 12 && done_at == 0; n++) begin
      @(negedge CpuClk);
      if (MemReq && !seen) begin
        seen = 1;
        chk("t4_restart_idx", 32'(WordIdx), 0);
        chk("t4_restart_addr", MemAddr, 32'h5000);
      end
      if (IDone) done_at = n;
      step();
    end
    IReq = 0;
    chk("t4_redone", 32'(done_at != 0), 1);
    step();

    // Requester drops IReq after first ack; the line still completes.
    IAddr = 32'h6000; IReq = 1; acks = 0; rdv = 0; done_at = 0;
    for (n = 0; n < 12 && done_at == 0; n++) begin
      @(negedge CpuClk);
      if (MemReq && MemAck) acks++;
      rdv += int'(RdValid);
      if (IDone) done_at = 1;
      step();
      if (acks >= 1) IReq = 0;
    end
    chk("t5_done", done_at, 1);
    chk("t5_rdvalid_cnt", rdv, 4);
    // Stray acks while idle.
    for (n = 0; n < 3; n++) begin
      @(negedge CpuClk);
      chk("t5_stray_rdvalid", 32'(RdValid), 0);
      step();
    end

    // Randomized traffic against the model.
    for (n = 0; n < 3000; n++) begin
      MemAck   = ($urandom_range(2) != 0);
      MemRdata = $urandom;
      dw_rand  = $urandom;
      if (CpuRst) CpuRst = 0;
      else if ($urandom_range(499) == 0) CpuRst = 1;
      if (IReq && e_idone) IReq = 0;
      else if (!IReq && $urandom_range(3) == 0) begin IReq = 1; IAddr = $urandom; end
      else if (IReq && $urandom_range(49) == 0) IReq = 0;
      if (DReq && e_ddone) DReq = 0;
      else if (!DReq && $urandom_range(3) == 0) begin
        DReq = 1; DAddr = $urandom; DWe = $urandom_range(1);
      end
      else if (DReq && $urandom_range(49) == 0) DReq = 0;
      step();
    end
    CpuRst = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
